// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring divider.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle; the divider is unaffected.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                sign_a, sign_b, neg_flag, div_zero, div_ovf;
    logic [XLEN-1:0]     mag_a, mag_b, special_res;
    logic [XLEN:0]       mul_sum, div_trial;
    logic [2*XLEN-1:0]   mul_step, div_step, step;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   prod_fast;
`endif

    // The accumulator holds the full magnitude product (multiply) or {remainder, quotient} (divide).
    function automatic logic [XLEN-1:0] finish_result(input logic [2:0] f, input logic neg,
                                                      input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem, res;
        prod = neg ? (~acc + (2*XLEN)'(1)) : acc;
        quo  = neg ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
        rem  = neg ? (~acc[2*XLEN-1:XLEN] + XLEN'(1)) : acc[2*XLEN-1:XLEN];
        case (f)
            3'b000:                 res = acc[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res = quo;
            default:                res = rem;
        endcase
        return res;
    endfunction

    always_comb begin
        sign_a = a[XLEN-1] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        sign_b = b[XLEN-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
        mag_a  = sign_a ? (~a + XLEN'(1)) : a;
        mag_b  = sign_b ? (~b + XLEN'(1)) : b;
        case (op)
            3'b001, 3'b100: neg_flag = sign_a ^ sign_b;
            3'b010, 3'b110: neg_flag = sign_a;
            default:        neg_flag = 1'b0;
        endcase
        div_zero    = op[2] && (b == '0);
        div_ovf     = (op == 3'b100 || op == 3'b110) && (a == MIN_NEG) && (b == '1);
        special_res = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
`ifdef MULDIV_FAST_MUL_EN
        prod_fast   = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`endif
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        // Shifted partial remainder needs one extra bit before the trial subtract.
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step      = op_q[2] ? div_step : mul_step;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN) begin
            acc_d = step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d  = ST_FIN;
                result_d = finish_result(op_q, neg_q, step);
            end
        end else if (start) begin
            op_d   = op;
            neg_d  = neg_flag;
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
            cnt_d  = CNT_W'(XLEN);
            if (div_zero || div_ovf) begin
                state_d  = ST_FIN;
                result_d = special_res;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!op[2]) begin
                state_d  = ST_FIN;
                result_d = finish_result(op, neg_flag, prod_fast);
`endif
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_FIN);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle corner sequences
// and randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int MAX_WAIT = 2*XLEN + 8;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            OP_MUL:    begin p = {32'b0, x} * {32'b0, y}; r = p[31:0];  end
            OP_MULH:   begin p = sx * sy;                 r = p[63:32]; end
            OP_MULHSU: begin p = sx * uy;                 r = p[63:32]; end
            OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            OP_DIV: begin
                if (y == 0)   r = 32'hFFFF_FFFF;
                else if (ovf) r = x;
                else begin p = sx / sy; r = p[31:0]; end
            end
            OP_DIVU: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else begin p = ux / uy; r = p[31:0]; end
            end
            OP_REM: begin
                if (y == 0)   r = x;
                else if (ovf) r = 32'h0;
                else begin p = sx % sy; r = p[31:0]; end
            end
            default: begin
                if (y == 0) r = x;
                else begin p = ux % uy; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        int l;
        if (!f[2])        l = MUL_LAT;
        else if (y == 0)  l = 1;
        else if ((f == OP_DIV || f == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) l = 1;
        else              l = LAT;
        return l;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 15);
            4:       v = 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called #1 after a clock edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = f;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat counts cycles after the accepting edge; the cycle right after it is cycle 1.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] res, input int elat);
        int lat;
        issue(f, x, y);
        wait_done(1, lat);
        $display("%s op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", name, f, x, y, result, lat);
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_res"}, 64'(result), 64'(res));
        @(posedge clk); #1;
        check({name, "_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int  lat;
        bit  seen_done;
        logic [2:0]  rf;
        logic [31:0] rx, ry;

        vecs[0]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT};
        vecs[1]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT};
        vecs[2]  = '{OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[3]  = '{OP_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 1};
        vecs[4]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[5]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[6]  = '{OP_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[7]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, MUL_LAT};
        vecs[8]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[9]  = '{OP_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, MUL_LAT};
        vecs[10] = '{OP_DIV,    32'h0000_0000, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[11] = '{OP_REM,    32'h0000_0005, 32'd0,         32'h0000_0005, 1};
        vecs[12] = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        LAT};
        vecs[13] = '{OP_REMU,   32'd100,       32'd7,         32'd2,         LAT};
        vecs[14] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[15] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[16] = '{OP_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, LAT};
        vecs[17] = '{OP_REM,    32'hFFFF_FFF8, 32'd3,         32'hFFFF_FFFE, LAT};
        vecs[18] = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   64'(busy),   64'(0));
        check("reset_done",   64'(done),   64'(0));
        check("reset_result", 64'(result), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++)
            run_op($sformatf("tbl%0d", i), vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].lat);

        // Flush during RUN: busy drops, no done, result holds the previous value (14).
        run_op("pre_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT);
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'(0));
        seen_done = 1'b0;
        repeat (LAT + 4) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        $display("flush op=%0d a=0x%08h b=0x%08h result=0x%08h", OP_DIV, 32'd1000, 32'd3, result);
        check("flush_no_done", 64'(seen_done), 64'(0));
        check("flush_result",  64'(result),    64'(14));

        // Flush wins over a simultaneous start.
        start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'(0));
        check("flush_start_done", 64'(done), 64'(0));
        @(posedge clk); #1;

        // A start while busy must be ignored (it would otherwise finish in one cycle).
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op = OP_REMU; a = 32'h0000_AAAA; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(4, lat);
        $display("ignore op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", OP_DIVU, 32'd100, 32'd7, result, lat);
        check("ignore_lat", 64'(lat),    64'(LAT));
        check("ignore_res", 64'(result), 64'(14));
        @(posedge clk); #1;

        // Reset in the middle of RUN.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("midreset busy=%0b done=%0b result=0x%08h", busy, done, result);
        check("midreset_busy",   64'(busy),   64'(0));
        check("midreset_done",   64'(done),   64'(0));
        check("midreset_result", 64'(result), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: second start is issued during the FIN cycle of the first.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat);
        $display("b2b_first result=0x%08h latency=%0d", result, lat);
        check("b2b_first_lat", 64'(lat),    64'(LAT));
        check("b2b_first_res", 64'(result), 64'(32'hFFFF_FFFD));
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
        check("b2b_nodone", 64'(done), 64'(0));
        check("b2b_busy",   64'(busy), 64'(1));
        wait_done(1, lat);
        $display("b2b_second result=0x%08h latency=%0d", result, lat);
        check("b2b_second_lat", 64'(lat),    64'(LAT));
        check("b2b_second_res", 64'(result), 64'(32'hFFFF_FFFF));
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            rx = pick_operand();
            ry = pick_operand();
            run_op($sformatf("rnd%0d", i), rf, rx, ry, ref_result(rf, rx, ry), ref_lat(rf, rx, ry));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M multiply/divide unit; successor to the combinational single-cycle MUL/DIV paths in the execute stage.
- Sits beside the ALU in EX; the pipeline stalls while busy=1 and captures result on the done pulse.
- Iterative radix-2 divider, and an iterative or single-cycle multiplier; RISC-V divide-by-zero and overflow semantics are built in.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted when busy=0 and flush=0.
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand, sampled on accept.
- b  input  XLEN  rs2 operand, sampled on accept.
- flush  input  1  kill in-flight op (branch mispredict/trap).
- busy  output  1  high in RUN state.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result, held until next done.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, busy=0, done=0, result=0, counter=0. Reset overrides everything, including mid-operation.
- States: IDLE, RUN, FIN. busy=(state==RUN); done=(state==FIN).
- IDLE/FIN with start=1, flush=0:
  - Latch op, a, b, and sign flags.
  - Signed ops (MUL* signed sides, DIV, REM) convert operands to magnitudes; sign flags are recorded.
  - If the op is a special case, go to FIN with the result loaded directly.
  - Otherwise go to RUN with counter=XLEN.
- IDLE/FIN with start=0: go to IDLE.
- RUN: one iteration per cycle; counter decrements; at counter==1 go to FIN. On entry to FIN, apply sign correction and load result.
- Latency: done is high exactly XLEN+1 cycles after the accepting edge; special cases take 1 cycle.
- Back-to-back: start asserted in the FIN cycle is accepted; done is not re-asserted until the new op finishes.
- start while busy=1 is ignored; no queueing.
- flush=1: next state IDLE, the in-flight op is discarded, no done, result unchanged. flush has priority over a simultaneous start.
- Multiply:
  - Shift-add over XLEN magnitude bits into a 2*XLEN accumulator.
  - Negate the product if the sign flags differ: MULH uses a^b signs; MULHSU uses the a sign only; MUL and MULHU need no correction of the low half.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring radix-2 on magnitudes.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Special cases (1-cycle):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow, a==1<<(XLEN-1) and b==all-ones: DIV gives a; REM gives 0.
  - Multiplies have no special case when not in fast mode.
- Width rules: all internal datapaths are XLEN or 2*XLEN; magnitude of the most-negative value is represented in XLEN unsigned bits.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined: multiplies use a single-cycle 2*XLEN product registered straight into FIN, so done comes 1 cycle after accept. The divider is unchanged.
- When undefined: multiplies use the iterative XLEN+1-cycle path. Results are bit-identical in both modes.

Test Plan:
- XLEN=32, op=DIV, a=-7 (0xFFFFFFF9), b=2 -> done 33 cycles after accept; result=0xFFFFFFFD (-3). Same operands with op=REM -> result=0xFFFFFFFF (-1).
- op=DIVU, b=0, a=0x1234 -> done 1 cycle later, result=0xFFFFFFFF. op=REMU with the same operands -> result=0x1234.
- op=DIV, a=0x80000000, b=0xFFFFFFFF -> 1-cycle done, result=0x80000000. op=REM with the same operands -> result=0.
- op=MULH, a=0xFFFFFFFF (-1), b=2 -> result=0xFFFFFFFF. MULHU with the same operands -> 0x00000001. MULHSU with the same operands -> 0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFFE.
- Start a DIV, assert flush at cycle 10 -> busy drops next cycle, no done, result keeps its previous value. Start issued with busy=1 -> ignored.
- Assert rst_n=0 mid-RUN -> next edge: busy=0, done=0, result=0. A start in the FIN cycle -> second op accepted, done pulses again after full latency.
